// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: word-organised data memory behind the pipeline's memory stage.
// It captures one load/store request, inserts WAIT_STATES idle cycles, then does
// the byte-lane access. It returns a one-cycle ack with load data already extended.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_req,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_data,
  input  logic [2:0]  i_funct3,
  input  logic        i_read_write,
  output logic        o_mem_ack,
  output logic [31:0] o_mem_data,
  output logic        o_mem_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        rw_q, rw_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Storage array; deliberately not reset so contents survive i_rst_n.
  logic [31:0] mem_array [DEPTH_WORDS];

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;
  logic          acc_err;
  logic          mem_we;

  // Select the addressed byte or half of a word and sign/zero-extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  ln,
                                              input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*ln +: 8];
    h = ln[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b100:  load_extend = {24'd0, b};
      3'b101:  load_extend = {16'd0, h};
      default: load_extend = word;
    endcase
  endfunction

  // Decode the captured request: error checks, lane steering and write enables.
  always_comb begin
    word_idx = addr_q[AW+1:2];
    lane     = addr_q[1:0];
    rd_word  = mem_array[word_idx];
    acc_err  = 1'b0;
    wr_data  = data_q;
    wr_be    = 4'b1111;
    case (funct3_q)
      3'b000, 3'b100: begin
        wr_data = {4{data_q[7:0]}};
        wr_be   = 4'b0001 << lane;
      end
      3'b001, 3'b101: begin
        acc_err = addr_q[0];
        wr_data = {2{data_q[15:0]}};
        wr_be   = lane[1] ? 4'b1100 : 4'b0011;
      end
      3'b010:  acc_err = (lane != 2'b00);
      default: acc_err = 1'b1;
    endcase
    if (|addr_q[31:AW+2]) acc_err = 1'b1;
    if (rw_q && funct3_q[2]) acc_err = 1'b1;
    mem_we = (state_q == S_ACCESS) && rw_q && !acc_err;
  end

  // Byte-lane write into the array on the ACCESS leaving edge.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_array[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Next-state and output logic of the request handshake FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    funct3_d = funct3_q;
    rw_d     = rw_q;
    ack_d    = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_mem_req) begin
          addr_d   = i_mem_addr;
          data_d   = i_mem_data;
          funct3_d = i_funct3;
          rw_d     = i_read_write;
          cnt_d    = 4'(WAIT_STATES);
          state_d  = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        ack_d   = 1'b1;
        err_d   = acc_err;
        rdata_d = (acc_err || rw_q) ? 32'd0 : load_extend(rd_word, lane, funct3_q);
        state_d = S_ACK;
      end
      S_ACK: begin
        // A request still held here is the one just served; park until it drops.
        state_d = i_mem_req ? S_RELEASE : S_IDLE;
      end
      S_RELEASE: begin
        if (!i_mem_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 32'd0;
      data_q   <= 32'd0;
      funct3_q <= 3'd0;
      rw_q     <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      funct3_q <= funct3_d;
      rw_q     <= rw_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign o_mem_ack  = ack_q;
  assign o_mem_data = rdata_q;
  assign o_mem_err  = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed test-plan cases plus random
// traffic compared against a byte-addressed reference memory.
module tb_data_mem_ctrl;

  localparam int DEPTH = 1024;
  localparam int WS    = 1;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_mem_req = 1'b0;
  logic [31:0] i_mem_addr = 32'd0;
  logic [31:0] i_mem_data = 32'd0;
  logic [2:0]  i_funct3 = 3'd0;
  logic        i_read_write = 1'b0;
  logic        o_mem_ack;
  logic [31:0] o_mem_data;
  logic        o_mem_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] ref_b [4*DEPTH];

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mem_req(i_mem_req),
    .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data), .i_funct3(i_funct3),
    .i_read_write(i_read_write), .o_mem_ack(o_mem_ack),
    .o_mem_data(o_mem_data), .o_mem_err(o_mem_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: byte-addressed memory; size/alignment/extension from the access rules.
  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                       input logic rw, output logic [31:0] ed, output logic ee);
    int size;
    bit sgn;
    bit rej;
    size = 4; sgn = 0; rej = 0;
    case (f)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: size = 1;
      3'd5: size = 2;
      default: rej = 1;
    endcase
    if (rw && (f == 3'd4 || f == 3'd5)) rej = 1;
    if ((a % size) != 0) rej = 1;
    if (a >= 32'(4*DEPTH)) rej = 1;
    ed = 32'd0;
    ee = rej;
    if (!rej) begin
      if (rw) begin
        for (int i = 0; i < size; i++) ref_b[a+i] = d[8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) ed[8*i +: 8] = ref_b[a+i];
        if (sgn && ed[8*size-1]) ed = ed | (32'hFFFFFFFF << (8*size));
      end
    end
  endtask

  // One full transaction; starts and ends 1 time unit after a rising edge.
  task automatic xact(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                      input logic rw, output logic [31:0] rd);
    logic [31:0] ed;
    logic ee;
    int n;
    model(a, d, f, rw, ed, ee);
    i_mem_req = 1'b1; i_mem_addr = a; i_mem_data = d; i_funct3 = f; i_read_write = rw;
    n = 0;
    while (n < 20) begin
      @(posedge i_clk); #1;
      n++;
      if (o_mem_ack) break;
      // Post-capture input changes must not affect the access.
      i_mem_addr = $urandom; i_mem_data = $urandom; i_funct3 = 3'($urandom);
      i_read_write = 1'($urandom);
    end
    chk("latency", n, WS + 2);
    chk("err", {31'd0, o_mem_err}, {31'd0, ee});
    chk("data", o_mem_data, ed);
    rd = o_mem_data;
    i_mem_req = 1'b0;
    @(posedge i_clk); #1;
    chk("ack_pulse", {31'd0, o_mem_ack}, 32'd0);
    chk("data_hold", o_mem_data, ed);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] ed;
    logic ee;
    int n;
    int acks;

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_ack", {31'd0, o_mem_ack}, 32'd0);
    chk("rst_data", o_mem_data, 32'd0);
    chk("rst_err", {31'd0, o_mem_err}, 32'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Prefill words 0..63 so later loads see known contents.
    for (int w = 0; w < 64; w++) xact(32'(4*w), $urandom, 3'd2, 1'b1, rd);

    // Directed test-plan cases
    xact(32'h10, 32'hDEADBEEF, 3'd2, 1'b1, rd);
    xact(32'h10, 32'h0, 3'd2, 1'b0, rd);  chk("tp_lw10", rd, 32'hDEADBEEF);
    xact(32'h20, 32'h0, 3'd2, 1'b1, rd);
    xact(32'h21, 32'h000000F0, 3'd0, 1'b1, rd);
    xact(32'h20, 32'h0, 3'd2, 1'b0, rd);  chk("tp_lw20", rd, 32'h0000F000);
    xact(32'h21, 32'h0, 3'd0, 1'b0, rd);  chk("tp_lb21", rd, 32'hFFFFFFF0);
    xact(32'h21, 32'h0, 3'd4, 1'b0, rd);  chk("tp_lbu21", rd, 32'h000000F0);
    xact(32'h30, 32'h11111111, 3'd2, 1'b1, rd);
    xact(32'h32, 32'h00008001, 3'd1, 1'b1, rd);
    xact(32'h30, 32'h0, 3'd2, 1'b0, rd);  chk("tp_lw30", rd, 32'h80011111);
    xact(32'h32, 32'h0, 3'd1, 1'b0, rd);  chk("tp_lh32", rd, 32'hFFFF8001);
    xact(32'h32, 32'h0, 3'd5, 1'b0, rd);  chk("tp_lhu32", rd, 32'h00008001);
    xact(32'h13, 32'h0, 3'd2, 1'b0, rd);
    xact(32'h34, 32'hCAFEF00D, 3'd2, 1'b1, rd);
    xact(32'h35, 32'h0000ABCD, 3'd1, 1'b1, rd);
    xact(32'h34, 32'h0, 3'd2, 1'b0, rd);  chk("tp_lw34", rd, 32'hCAFEF00D);
    xact(32'h30, 32'h0, 3'd7, 1'b0, rd);
    xact(32'h00001000, 32'h0, 3'd2, 1'b0, rd);
    xact(32'h20, 32'h1, 3'd4, 1'b1, rd);

    // Request held across its own ack: exactly one ack.
    model(32'h10, 32'h0, 3'd2, 1'b0, ed, ee);
    i_mem_req = 1'b1; i_mem_addr = 32'h10; i_funct3 = 3'd2; i_read_write = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge i_clk); #1;
      n++;
      if (o_mem_ack) break;
    end
    chk("hs_latency", n, WS + 2);
    chk("hs_data", o_mem_data, ed);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk); #1;
      if (o_mem_ack) acks++;
    end
    chk("hs_extra_acks", acks, 0);
    i_mem_req = 1'b0;
    @(posedge i_clk); #1;
    xact(32'h10, 32'h0, 3'd2, 1'b0, rd);

    // Reset during WAIT of a store: no ack, no write.
    i_mem_req = 1'b1; i_mem_addr = 32'h40; i_mem_data = 32'h12345678;
    i_funct3 = 3'd2; i_read_write = 1'b1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk); #1;
      if (o_mem_ack) acks++;
    end
    i_mem_req = 1'b0;
    chk("mid_rst_data", o_mem_data, 32'd0);
    chk("mid_rst_err", {31'd0, o_mem_err}, 32'd0);
    i_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk); #1;
      if (o_mem_ack) acks++;
    end
    chk("mid_rst_acks", acks, 0);
    xact(32'h40, 32'h0, 3'd2, 1'b0, rd);

    // Random traffic over the prefilled region plus occasional out-of-range.
    for (int k = 0; k < 200; k++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) a = 32'h1000 + 32'($urandom_range(0, 4095));
      xact(a, $urandom, 3'($urandom), 1'($urandom), rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Word-organised data memory with controller, sitting directly downstream of the pipeline's memory stage. It accepts a load/store request (address, right-justified store data, funct3, read/write), waits a fixed number of wait states, and performs the access with byte-lane steering. It returns a one-cycle acknowledge with load data already sign- or zero-extended for direct write into rd.

## Interface
- DEPTH_WORDS, 1024 — number of 32-bit words in the array; power of two.
- WAIT_STATES, 1 — extra cycles inserted between request capture and array access; 0–15.

- i_clk  input  1  CPU clock; all state updates on the rising edge.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_mem_req  input  1  request valid; level, held until acknowledged.
- i_mem_addr  input  32  byte address.
- i_mem_data  input  32  store data, right-justified: byte in [7:0], half in [15:0].
- i_funct3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_read_write  input  1  0 = load, 1 = store.
- o_mem_ack  output  1  one-cycle completion pulse.
- o_mem_data  output  32  extended load data; valid while o_mem_ack=1, held afterwards.
- o_mem_err  output  1  qualifies o_mem_ack: the access was rejected.

## Operation
- States: IDLE, WAIT, ACCESS, ACK, RELEASE. Wait counter cnt is 4 bits.
- IDLE, i_mem_req=1:
  - Latch addr, data, funct3 and read_write.
  - Load cnt = WAIT_STATES.
  - Go to ACCESS if WAIT_STATES=0, else to WAIT.
- WAIT: decrement cnt each edge; go to ACCESS on the edge where cnt=1.
- ACCESS: on the leaving edge, perform the access, register o_mem_data and o_mem_err, set o_mem_ack=1, go to ACK.
- ACK: on the next edge, clear o_mem_ack; go to RELEASE if i_mem_req=1, else to IDLE.
- RELEASE: stay until i_mem_req=0, then go to IDLE. A request held across its own ack is never serviced twice.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Lane = addr[1:0].
- Error conditions. Any one sets o_mem_err=1 with o_mem_data=0, and suppresses the array write:
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠00.
  - addr ≥ 4*DEPTH_WORDS.
  - funct3 011, 110 or 111.
  - Store with funct3 100 or 101.
- Store byte: write i_mem_data[7:0] into lane addr[1:0]; other lanes unchanged.
- Store half: write [15:0] into lanes {addr[1],0} and {addr[1],1}; other lanes unchanged.
- Store word: write all four lanes.
- Load: select the byte or half at the lane, then extend:
  - B: sign-extend bit 7.
  - H: sign-extend bit 15.
  - BU, HU: zero-extend.
  - W: the word unchanged.
- Stores also ack, with o_mem_data=0.
- The array has no reset; contents survive i_rst_n.

## Timing
- Reset (async assert, sync release): state=IDLE, cnt=0, o_mem_ack=0, o_mem_data=0, o_mem_err=0.
- Reset asserted mid-transaction: the transaction is abandoned and no ack is produced.
  - A store is not written if reset arrives before the ACCESS leaving edge.
- Latency: request sampled in IDLE at edge E0; o_mem_ack high in the cycle after edge E(WAIT_STATES+1).
  - WAIT_STATES=0: ack in the cycle after E1.
  - WAIT_STATES=1: ack in the cycle after E2.
- o_mem_ack is high for exactly one cycle per accepted request.
- o_mem_data and o_mem_err hold their values until the next ACCESS edge.
- Request inputs are sampled only in IDLE. Changes to them after capture are ignored.
- Back-to-back requests: minimum spacing between ack pulses is WAIT_STATES+3 cycles (ACK, then IDLE or RELEASE, then a new capture).
- Store-then-load to the same word returns the new data; there is no bypass need, since accesses are sequential.

## Test plan
- Reset, WAIT_STATES=1: all outputs 0.
  - SW addr 0x10 data 0xDEADBEEF → ack in the cycle after E2, err=0.
  - LW 0x10 → o_mem_data=0xDEADBEEF.
- Byte lanes:
  - SW 0x20 = 0x00000000; SB 0x21 data 0x000000F0 → LW 0x20 returns 0x0000F000.
  - LB 0x21 → 0xFFFFFFF0.
  - LBU 0x21 → 0x000000F0.
- Halves:
  - SH 0x32 data 0x00008001 over word 0x11111111 → LW 0x30 returns 0x80011111.
  - LH 0x32 → 0xFFFF8001.
  - LHU 0x32 → 0x00008001.
- Errors:
  - LW 0x13 → ack, err=1, data 0.
  - SH 0x35 → err=1 and word 0x34 unchanged.
  - funct3 111 → err=1.
  - Address 4*DEPTH_WORDS → err=1.
- Handshake:
  - i_mem_req held high 10 cycles past ack → exactly one ack pulse.
  - Drop req then re-raise → a second ack after WAIT_STATES+1 edges.
- Reset mid-op: assert i_rst_n=0 during WAIT of SW 0x40 data 0x12345678 → no ack; a later LW 0x40 returns the prior contents.
